// File: rtl/axi4_frame_writer.sv
// ---------------------------------------------------------------------------
// axi4_frame_writer
//   Stream-to-memory-mapped AXI4 write master for the video path. Pixel words
//   arriving in the clk_100Mhz domain are buffered in a first-word-fall-through
//   FIFO and written to DDR as INCR bursts into a ring of NUM_FRAMES frame
//   buffers. A frame shorter than a burst (or the tail of any frame) is
//   flushed as one short burst once its s_last word is in the FIFO.
//
// Ports
//   clk_100Mhz, rst_n         sole clock, asynchronous active-low reset
//   enable                    1 = new bursts may start (current burst always completes)
//   s_data/s_valid/s_last     pixel word stream, s_last marks end of frame
//   s_ready                   high while the FIFO has room
//   AW*/W*/B*                 AXI4 write address / data / response channels
//   frame_done                one-cycle pulse after the B of a frame's final burst
//   last_frame_idx            buffer index of the most recently completed frame
//   frame_ovf                 sticky: a frame filled its buffer without s_last
//   bresp_err                 sticky: a non-OKAY write response was seen
//   fifo_level                words currently held in the FIFO
// ---------------------------------------------------------------------------
module axi4_frame_writer #(
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        AXI_DATA_WIDTH  = 64,
    parameter int                        BURST_LEN       = 64,
    parameter int                        FIFO_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h0100_0000,
    parameter int                        FRAME_BYTES     = 153600,
    parameter int                        NUM_FRAMES      = 3
) (
    input  logic                                                clk_100Mhz,
    input  logic                                                rst_n,
    input  logic                                                enable,
    // pixel stream
    input  logic [AXI_DATA_WIDTH-1:0]                           s_data,
    input  logic                                                s_valid,
    input  logic                                                s_last,
    output logic                                                s_ready,
    // AXI4 write address channel
    output logic [AXI_ADDR_WIDTH-1:0]                           AWADDR,
    output logic                                                AWVALID,
    input  logic                                                AWREADY,
    output logic [7:0]                                          AWLEN,
    output logic [2:0]                                          AWSIZE,
    output logic [1:0]                                          AWBURST,
    output logic [3:0]                                          AWCACHE,
    output logic [2:0]                                          AWPROT,
    // AXI4 write data channel
    output logic [AXI_DATA_WIDTH-1:0]                           WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]                         WSTRB,
    output logic                                                WLAST,
    output logic                                                WVALID,
    input  logic                                                WREADY,
    // AXI4 write response channel
    input  logic [1:0]                                          BRESP,
    input  logic                                                BVALID,
    output logic                                                BREADY,
    // status
    output logic                                                frame_done,
    output logic [$clog2(NUM_FRAMES > 1 ? NUM_FRAMES : 2)-1:0] last_frame_idx,
    output logic                                                frame_ovf,
    output logic                                                bresp_err,
    output logic [$clog2(FIFO_DEPTH):0]                         fifo_level
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int PTRW  = $clog2(FIFO_DEPTH);
    localparam int LVLW  = PTRW + 1;
    localparam int LENW  = $clog2(BURST_LEN) + 1;
    localparam int OFFW  = $clog2(FRAME_BYTES + 1);
    localparam int IDXW  = $clog2(NUM_FRAMES > 1 ? NUM_FRAMES : 2);

    typedef struct packed {
        logic                      last;
        logic [AXI_DATA_WIDTH-1:0] data;
    } fifo_word_t;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    fifo_word_t            mem [FIFO_DEPTH];
    logic [PTRW-1:0]       wr_ptr, rd_ptr;
    logic [LVLW-1:0]       level;
    logic [LVLW-1:0]       eof_cnt;      // s_last words currently in the FIFO
    fifo_word_t            head;
    logic                  push, pop;

    assign head       = mem[rd_ptr];
    assign s_ready    = (level != LVLW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign pop        = WVALID && WREADY;
    assign fifo_level = level;
    assign WDATA      = head.data;

    always_ff @(posedge clk_100Mhz) begin
        if (push) mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            eof_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVLW'(1);
                2'b01:   level <= level - LVLW'(1);
                default: ;
            endcase
            case ({push && s_last, pop && head.last})
                2'b10:   eof_cnt <= eof_cnt + LVLW'(1);
                2'b01:   eof_cnt <= eof_cnt - LVLW'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst sizing: words up to and including the first resident s_last,
    // capped at BURST_LEN and at what is left of the current buffer.
    // Only the first BURST_LEN entries matter; a later s_last cannot
    // shorten the burst.
    // ------------------------------------------------------------------
    logic            eof_found;
    logic [LENW-1:0] eof_words;
    logic [OFFW-1:0] offset;
    logic [OFFW-1:0] rem_words;
    logic [LENW-1:0] launch_len;
    logic            go;

    always_comb begin
        eof_found = 1'b0;
        eof_words = LENW'(BURST_LEN);
        for (int i = 0; i < BURST_LEN; i++) begin
            if (!eof_found && (LVLW'(i) < level) && mem[rd_ptr + PTRW'(i)].last) begin
                eof_found = 1'b1;
                eof_words = LENW'(i + 1);
            end
        end
    end

    always_comb begin
        rem_words  = (OFFW'(FRAME_BYTES) - offset) >> SIZE;
        launch_len = eof_words;
        if (rem_words < OFFW'(eof_words)) launch_len = LENW'(rem_words);
    end

    // Either a full burst is buffered or a frame end is; both guarantee
    // every beat of the burst is already in the FIFO, so WVALID never
    // has to drop mid-burst.
    assign go = enable && ((level >= LVLW'(BURST_LEN)) || (eof_cnt != '0));

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    state_t                    state;
    logic [LENW-1:0]           burst_len;
    logic [LENW-1:0]           beat_cnt;
    logic                      burst_eof;   // burst carried the frame's s_last
    logic [IDXW-1:0]           buf_idx;
    logic [AXI_ADDR_WIDTH-1:0] buf_base;    // base of buf_idx, tracked incrementally
    logic [OFFW-1:0]           offset_next;

    assign offset_next = offset + (OFFW'(burst_len) << SIZE);

    assign AWSIZE  = 3'(SIZE);
    assign AWBURST = 2'b01;
    assign AWCACHE = 4'b1111;
    assign AWPROT  = 3'b010;
    assign WSTRB   = '1;

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            AWADDR         <= FRAME_BASE_ADDR;
            AWVALID        <= 1'b0;
            AWLEN          <= '0;
            WVALID         <= 1'b0;
            WLAST          <= 1'b0;
            BREADY         <= 1'b0;
            frame_done     <= 1'b0;
            last_frame_idx <= IDXW'(NUM_FRAMES - 1);
            frame_ovf      <= 1'b0;
            bresp_err      <= 1'b0;
            burst_len      <= '0;
            beat_cnt       <= '0;
            burst_eof      <= 1'b0;
            buf_idx        <= '0;
            buf_base       <= FRAME_BASE_ADDR;
            offset         <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        burst_len <= launch_len;
                        AWLEN     <= 8'(launch_len - LENW'(1));
                        AWADDR    <= buf_base + AXI_ADDR_WIDTH'(offset);
                        AWVALID   <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (AWREADY) begin
                        AWVALID   <= 1'b0;
                        WVALID    <= 1'b1;
                        WLAST     <= (burst_len == LENW'(1));
                        beat_cnt  <= '0;
                        burst_eof <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (WVALID && WREADY) begin
                        if (head.last) burst_eof <= 1'b1;
                        beat_cnt <= beat_cnt + LENW'(1);
                        if (WLAST) begin
                            WVALID <= 1'b0;
                            WLAST  <= 1'b0;
                            BREADY <= 1'b1;
                            state  <= RESP;
                        end else begin
                            // raise WLAST for the beat after this one if it is the final one
                            WLAST <= (beat_cnt + LENW'(2) == burst_len);
                        end
                    end
                end
                RESP: begin
                    if (BVALID && BREADY) begin
                        BREADY <= 1'b0;
                        state  <= IDLE;
                        if (BRESP != 2'b00) bresp_err <= 1'b1;
                        if (burst_eof) begin
                            frame_done     <= 1'b1;
                            last_frame_idx <= buf_idx;
                            offset         <= '0;
                            if (buf_idx == IDXW'(NUM_FRAMES - 1)) begin
                                buf_idx  <= '0;
                                buf_base <= FRAME_BASE_ADDR;
                            end else begin
                                buf_idx  <= buf_idx + IDXW'(1);
                                buf_base <= buf_base + AXI_ADDR_WIDTH'(FRAME_BYTES);
                            end
                        end else if (offset_next == OFFW'(FRAME_BYTES)) begin
                            // buffer full with no frame end: keep writing over the same buffer
                            frame_ovf <= 1'b1;
                            offset    <= '0;
                        end else begin
                            offset <= offset_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_frame_writer.sv
module tb_axi4_frame_writer;

    localparam int          BL   = 64;
    localparam int          FD   = 256;
    localparam int          FB   = 153600;
    localparam int          NF   = 3;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk_100Mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0] AWADDR;
    logic        AWVALID, AWREADY = 1'b0;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST;
    logic [3:0]  AWCACHE;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0, BREADY;
    logic        frame_done, frame_ovf, bresp_err;
    logic [1:0]  last_frame_idx;
    logic [8:0]  fifo_level;

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi4_frame_writer #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .BURST_LEN(BL), .FIFO_DEPTH(FD),
        .FRAME_BASE_ADDR(BASE), .FRAME_BYTES(FB), .NUM_FRAMES(NF)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .frame_done(frame_done), .last_frame_idx(last_frame_idx), .frame_ovf(frame_ovf),
        .bresp_err(bresp_err), .fifo_level(fifo_level)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [63:0] sq_data[$];     // every word accepted, in order
    bit          sq_last[$];
    int          asg = 0;        // first word not yet claimed by a burst
    int          wptr = 0;       // next word expected on W
    int          beat = 0, cur_len = 0;
    bit          cur_eof = 0, busy = 0, fd_pend = 0;
    int          m_idx = 0, m_off = 0, m_last_idx = NF - 1;
    bit          m_ovf = 0, m_berr = 0;
    logic [31:0] aw_log_addr[$];
    int          aw_log_len[$];
    int          fd_log[$];
    bit          mon_en = 0;

    // ---------------- slave / stimulus controls ----------------
    bit aw_hs_seen = 0, b_hs_seen = 0;
    int aw_stall = 0, aw_cnt = 0;
    bit aw_block = 0, w_toggle = 0, inject_err = 0, abort_drv = 0;
    int seq = 0;

    logic        p_awstall = 0, p_wstall = 0, p_wlast = 0;
    logic [31:0] p_awaddr = '0;
    logic [7:0]  p_awlen = '0;
    logic [63:0] p_wdata = '0;

    // ---------------- compare process ----------------
    always @(negedge clk_100Mhz) begin
        aw_hs_seen = AWVALID && AWREADY;
        b_hs_seen  = BVALID && BREADY;
        if (mon_en && rst_n) begin
            chk("frame_done", frame_done, fd_pend);
            fd_pend = 0;
            chk("last_frame_idx", last_frame_idx, m_last_idx);
            chk("frame_ovf", frame_ovf, m_ovf);
            chk("bresp_err", bresp_err, m_berr);
            chk("fifo_level", fifo_level, sq_data.size() - wptr);
            chk("s_ready", s_ready, (sq_data.size() - wptr) != FD);
            if (p_awstall) begin
                chk("aw_hold_valid", AWVALID, 1);
                chk("aw_hold_addr", AWADDR, p_awaddr);
                chk("aw_hold_len", AWLEN, p_awlen);
            end
            if (p_wstall) begin
                chk("w_hold_valid", WVALID, 1);
                chk("w_hold_data", WDATA, p_wdata);
                chk("w_hold_last", WLAST, p_wlast);
            end
            if (AWVALID && AWREADY) begin
                int n, rem;
                rem = (FB - m_off) / 8;
                n = 0;
                while (n < BL && n < rem && asg + n < sq_data.size()) begin
                    n++;
                    if (sq_last[asg+n-1]) break;
                end
                chk("aw_busy", busy, 0);
                chk("awaddr", AWADDR, BASE + m_idx * FB + m_off);
                chk("awlen", AWLEN, n - 1);
                chk("awsize", AWSIZE, 3);
                chk("awburst", AWBURST, 1);
                chk("awcache", AWCACHE, 15);
                chk("awprot", AWPROT, 2);
                cur_len = n;
                cur_eof = (n > 0) && sq_last[asg+n-1];
                asg += n;
                beat = 0;
                busy = 1;
                aw_log_addr.push_back(AWADDR);
                aw_log_len.push_back(int'(AWLEN));
            end
            if (WVALID && WREADY) begin
                chk("w_in_burst", busy, 1);
                chk("wdata", WDATA, (wptr < sq_data.size()) ? sq_data[wptr] : 64'hX);
                chk("wlast", WLAST, beat == cur_len - 1);
                chk("wstrb", WSTRB, 8'hFF);
                beat++;
                wptr++;
            end
            if (BVALID && BREADY) begin
                chk("beats_per_burst", beat, cur_len);
                if (BRESP != 2'b00) m_berr = 1;
                m_off += cur_len * 8;
                if (cur_eof) begin
                    fd_pend    = 1;
                    m_last_idx = m_idx;
                    fd_log.push_back(m_idx);
                    m_idx = (m_idx + 1) % NF;
                    m_off = 0;
                end else if (m_off == FB) begin
                    m_ovf = 1;
                    m_off = 0;
                end
                busy = 0;
            end
            if (s_valid && s_ready) begin
                sq_data.push_back(s_data);
                sq_last.push_back(s_last);
            end
            p_awstall = AWVALID && !AWREADY;
            p_awaddr  = AWADDR;
            p_awlen   = AWLEN;
            p_wstall  = WVALID && !WREADY;
            p_wdata   = WDATA;
            p_wlast   = WLAST;
        end
    end

    // ---------------- AXI slave responder ----------------
    initial begin
        forever begin
            @(posedge clk_100Mhz);
            #1;
            if (!rst_n) begin
                AWREADY = 0; BVALID = 0; BRESP = 2'b00; aw_cnt = 0;
            end else begin
                if (aw_hs_seen) aw_cnt = 0;
                if (aw_block) AWREADY = 0;
                else if (aw_stall == 0) AWREADY = 1;
                else begin
                    if (AWVALID && !AWREADY) aw_cnt++;
                    AWREADY = AWVALID && (aw_cnt >= aw_stall);
                end
                if (w_toggle) WREADY = ~WREADY;
                else WREADY = 1;
                if (b_hs_seen) begin
                    BVALID = 0; BRESP = 2'b00;
                end else if (BREADY && !BVALID) begin
                    BVALID = 1;
                    BRESP = inject_err ? 2'b10 : 2'b00;
                    inject_err = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic send(input int n, input bit last_at_end);
        for (int i = 0; i < n && !abort_drv; i++) begin
            int t;
            s_valid = 1;
            s_data  = {$urandom(), 32'(seq)};
            s_last  = last_at_end && (i == n - 1);
            t = 0;
            @(negedge clk_100Mhz);
            while (!s_ready && t < 20000 && !abort_drv) begin
                t++;
                @(negedge clk_100Mhz);
            end
            if (t >= 20000) begin
                checks++; errors++;
                $display("FAIL drv_timeout: word %0d not accepted, got s_ready=0 expected 1", seq);
            end
            @(posedge clk_100Mhz);
            #1;
            seq++;
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic wait_quiet(input int target, input int budget);
        int t;
        t = 0;
        while (!(wptr >= target && !busy) && t < budget) begin
            @(posedge clk_100Mhz);
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL wait_timeout: got %0d words written expected %0d", wptr, target);
        end
        repeat (3) @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_awvalid"}, AWVALID, 0);
        chk({tag, "_wvalid"}, WVALID, 0);
        chk({tag, "_wlast"}, WLAST, 0);
        chk({tag, "_bready"}, BREADY, 0);
        chk({tag, "_awaddr"}, AWADDR, 32'h0100_0000);
        chk({tag, "_awlen"}, AWLEN, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_last_idx"}, last_frame_idx, 2);
        chk({tag, "_frame_ovf"}, frame_ovf, 0);
        chk({tag, "_bresp_err"}, bresp_err, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int s0, f0, tgt, t;
        #12;
        check_reset("rst0");
        @(posedge clk_100Mhz); #1;
        rst_n  = 1;
        mon_en = 1;
        enable = 1;

        // 1: 2400-word frame -> 37 full bursts and one 32-beat tail
        s0 = aw_log_addr.size(); f0 = fd_log.size();
        send(2400, 1);
        wait_quiet(sq_data.size(), 20000);
        chk("t1_bursts", aw_log_addr.size() - s0, 38);
        if (aw_log_addr.size() >= s0 + 38) begin
            chk("t1_addr0", aw_log_addr[s0], 32'h0100_0000);
            chk("t1_addr1", aw_log_addr[s0+1], 32'h0100_0200);
            chk("t1_addr37", aw_log_addr[s0+37], 32'h0100_4A00);
            chk("t1_len0", aw_log_len[s0], 63);
            chk("t1_len37", aw_log_len[s0+37], 31);
        end
        chk("t1_done_cnt", fd_log.size() - f0, 1);
        chk("t1_last_idx", last_frame_idx, 0);

        // 2: three short frames back to back -> buffers 1, 2, then wrap to 0
        s0 = aw_log_addr.size(); f0 = fd_log.size();
        send(10, 1); send(10, 1); send(10, 1);
        wait_quiet(sq_data.size(), 2000);
        chk("t2_bursts", aw_log_addr.size() - s0, 3);
        if (aw_log_addr.size() >= s0 + 3) begin
            chk("t2_base1", aw_log_addr[s0], 32'h0102_5800);
            chk("t2_base2", aw_log_addr[s0+1], 32'h0104_B000);
            chk("t2_wrap", aw_log_addr[s0+2], 32'h0100_0000);
        end
        if (fd_log.size() >= f0 + 3) begin
            chk("t2_idx_a", fd_log[f0], 1);
            chk("t2_idx_b", fd_log[f0+1], 2);
            chk("t2_idx_c", fd_log[f0+2], 0);
        end
        chk("t2_last_idx", last_frame_idx, 0);

        // 3: single 10-word frame -> one short burst
        s0 = aw_log_addr.size();
        send(10, 1);
        wait_quiet(sq_data.size(), 2000);
        chk("t3_bursts", aw_log_addr.size() - s0, 1);
        if (aw_log_addr.size() > s0) begin
            chk("t3_addr", aw_log_addr[s0], 32'h0102_5800);
            chk("t3_len", aw_log_len[s0], 9);
        end
        chk("t3_last_idx", last_frame_idx, 1);

        // 4: AWREADY held off ~20 cycles, WREADY toggling
        s0 = aw_log_addr.size();
        aw_stall = 20; w_toggle = 1;
        send(64, 1);
        wait_quiet(sq_data.size(), 3000);
        aw_stall = 0; w_toggle = 0;
        if (aw_log_addr.size() > s0) begin
            chk("t4_addr", aw_log_addr[s0], 32'h0104_B000);
            chk("t4_len", aw_log_len[s0], 63);
        end
        chk("t4_last_idx", last_frame_idx, 2);

        // 5: no s_last for more than a buffer; first burst answered with SLVERR
        s0 = aw_log_addr.size();
        inject_err = 1;
        send(19300, 0);
        tgt = sq_data.size() - 36;
        wait_quiet(tgt, 60000);
        chk("t5_bursts", aw_log_addr.size() - s0, 301);
        if (aw_log_addr.size() >= s0 + 301) begin
            chk("t5_addr299", aw_log_addr[s0+299], 32'h0102_5600);
            chk("t5_addr300", aw_log_addr[s0+300], 32'h0100_0000);
        end
        chk("t5_ovf", frame_ovf, 1);
        chk("t5_berr", bresp_err, 1);
        chk("t5_level", fifo_level, 36);
        s0 = aw_log_addr.size();
        send(1, 1);
        wait_quiet(sq_data.size(), 2000);
        if (aw_log_addr.size() > s0) begin
            chk("t5_flush_addr", aw_log_addr[s0], 32'h0100_0200);
            chk("t5_flush_len", aw_log_len[s0], 36);
        end
        chk("t5_last_idx", last_frame_idx, 0);

        // 6: fill FIFO behind a blocked AW channel, then reset mid-burst
        aw_block = 1;
        fork
            send(300, 1);
        join_none
        repeat (400) @(posedge clk_100Mhz);
        #1;
        chk("t6_full_level", fifo_level, 256);
        chk("t6_full_ready", s_ready, 0);
        chk("t6_aw_stuck", AWVALID, 1);
        chk("t6_aw_addr", AWADDR, 32'h0102_5800);
        aw_block = 0;
        t = 0;
        while (!(busy && beat >= 10) && t < 2000) begin
            @(posedge clk_100Mhz);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL t6_data_timeout: got %0d beats expected 10", beat);
        end
        #3;
        mon_en = 0;
        abort_drv = 1;
        rst_n = 0;
        #1;
        check_reset("rst_mid");
        repeat (3) @(posedge clk_100Mhz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
